// File: rtl/double_dabble.sv
// 16-bit unsigned binary to 5-digit BCD, shift-and-add-3, one bit per clock.
// Digits and done update 16 cycles after start is accepted; start is ignored while busy.
module double_dabble (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] binary_in,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd4,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [19:0] adj;
  logic [35:0] shifted;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
    // The MSB of the adjusted scratch is dropped by the shift; it is always 0.
    shifted = {adj, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = binary_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[35:16];
        shift_d   = shifted[15:0];
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          bcd_d   = shifted[35:16];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bcd0 = bcd_q[3:0];
  assign bcd1 = bcd_q[7:4];
  assign bcd2 = bcd_q[11:8];
  assign bcd3 = bcd_q[15:12];
  assign bcd4 = bcd_q[19:16];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_double_dabble.sv
// Directed bench for double_dabble: inputs change and outputs are sampled on the falling edge.
module tb_double_dabble;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] binary_in;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  double_dabble dut (
    .clk(clk), .reset(reset), .start(start), .binary_in(binary_in),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] digits();
    return {bcd4, bcd3, bcd2, bcd1, bcd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns on the falling edge right after the accepting edge.
  task automatic start_conv(input logic [15:0] val);
    @(negedge clk);
    binary_in = val;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Counts falling edges until done is seen; busy must stay high meanwhile.
  task automatic wait_done(input string tag, output int cycles);
    int busy_lo;
    busy_lo = 0;
    cycles  = 0;
    while (!done && cycles < 40) begin
      if (!busy) busy_lo++;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_busy_held"}, busy_lo, 0);
    check({tag, "_done_seen"}, {31'd0, done}, 1);
  endtask

  task automatic convert(input string tag, input logic [15:0] val, input logic [19:0] exp);
    start_conv(val);
    check({tag, "_busy_rise"}, {31'd0, busy}, 1);
    wait_done(tag, cyc);
    check({tag, "_latency"}, cyc, 16);
    check({tag, "_digits"}, {12'd0, digits()}, {12'd0, exp});
    check({tag, "_busy_low"}, {31'd0, busy}, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
    check({tag, "_hold"}, {12'd0, digits()}, {12'd0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    binary_in = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_digits", {12'd0, digits()}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    binary_in = 16'd4321;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {11'd0, busy, done, digits()}, 0);
    end

    convert("c754", 16'd754, 20'h00754);
    convert("c65535", 16'd65535, 20'h65535);
    convert("c0", 16'd0, 20'h00000);
    convert("c4095", 16'd4095, 20'h04095);

    // Restart attempt mid-conversion with a changed input is ignored.
    start_conv(16'd754);
    repeat (5) @(negedge clk);
    binary_in = 16'd1234;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_done("ign", cyc);
    check("ign_latency", cyc, 10);
    check("ign_digits", {12'd0, digits()}, 32'h00754);
    @(negedge clk);
    check("ign_no_requeue", {30'd0, busy, done}, 0);
    convert("c1234", 16'd1234, 20'h01234);

    // Back-to-back: start presented during the done cycle.
    start_conv(16'd42);
    wait_done("b2b_a", cyc);
    check("b2b_a_digits", {12'd0, digits()}, 32'h00042);
    binary_in = 16'd9999;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    check("b2b_busy_rise", {31'd0, busy}, 1);
    check("b2b_done_fall", {31'd0, done}, 0);
    check("b2b_digits_kept", {12'd0, digits()}, 32'h00042);
    wait_done("b2b_b", cyc);
    check("b2b_latency", cyc, 16);
    check("b2b_digits", {12'd0, digits()}, 32'h09999);

    // Reset partway through a conversion.
    @(negedge clk);
    start_conv(16'd31337);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_digits", {12'd0, digits()}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("mid_rst_no_done", seen, 0);
    end
    convert("post_rst", 16'd31337, 20'h31337);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
